// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus between the PIPE stage registers and the hazard controller.
// The pipeline side (master) drives the stage icodes/registers/status and receives the
// per-stage stall/bubble controls; the controller side (slave) does the opposite.
interface pipe_hazard_ctrl_if #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 3
);
  logic [ICODE_W-1:0] D_icode;
  logic [REG_W-1:0]   d_srcA;
  logic [REG_W-1:0]   d_srcB;
  logic [ICODE_W-1:0] E_icode;
  logic [REG_W-1:0]   E_dstM;
  logic               e_Cnd;
  logic [ICODE_W-1:0] M_icode;
  logic [STAT_W-1:0]  m_stat;
  logic [STAT_W-1:0]  W_stat;

  logic F_stall;
  logic D_stall;
  logic D_bubble;
  logic E_stall;
  logic E_bubble;
  logic M_stall;
  logic M_bubble;
  logic W_stall;
  logic W_bubble;
  logic halted;
  logic mem_busy;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
           W_stall, W_bubble, halted, mem_busy
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
           W_stall, W_bubble, halted, mem_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86 PIPE hazard controller: classic load-use / ret / mispredict / exception controls,
// plus a data-memory wait-state FSM and a sticky halt state.
// Optional macro HAZ_PERF_CNT_EN adds stall/bubble/memory-wait performance counters.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// S_IDLE    | classic control; a memory op in M starts a hold when MEM_LAT > 1
// S_WAIT    | memory wait in progress, pipeline held, cnt counts down to 1
// S_RELEASE | one free cycle so M advances and the same op cannot re-trigger
// S_HALT    | exception/halt reached W; everything held until reset
module pipe_hazard_ctrl #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 3,
  parameter int MEM_LAT = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cnt_stall
  , output logic [CNT_W-1:0] cnt_bubble
  , output logic [CNT_W-1:0] cnt_memwait
`endif
);

  localparam logic [ICODE_W-1:0] I_RMMOVQ = ICODE_W'(4);
  localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] I_CALL   = ICODE_W'(8);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] I_PUSHQ  = ICODE_W'(10);
  localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(11);
  localparam logic [REG_W-1:0]   RNONE    = {REG_W{1'b1}};
  localparam logic [STAT_W-1:0]  S_HLT    = STAT_W'(2);
  localparam logic [STAT_W-1:0]  S_ADR    = STAT_W'(3);
  localparam logic [STAT_W-1:0]  S_INS    = STAT_W'(4);

  // The first hold cycle happens in IDLE, so the wait counter only covers MEM_LAT-2 cycles.
  localparam bit HAS_WAIT  = (MEM_LAT > 1);
  localparam bit LONG_WAIT = (MEM_LAT > 2);
  localparam int CW        = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = (MEM_LAT > 2) ? CW'(MEM_LAT - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic loaduse, ret, mispred, mem_op, exc_m, exc_w, hold;
  logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble;
  logic w_stall, w_bubble, halted, mem_busy;

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  // Classic PIPE hazard terms from the current stage contents.
  always_comb begin
    loaduse = ((hz.E_icode == I_MRMOVQ) || (hz.E_icode == I_POPQ)) &&
              (hz.E_dstM != RNONE) &&
              ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
    ret     = (hz.D_icode == I_RET) || (hz.E_icode == I_RET) || (hz.M_icode == I_RET);
    mispred = (hz.E_icode == I_JXX) && !hz.e_Cnd;
    mem_op  = (hz.M_icode == I_RMMOVQ) || (hz.M_icode == I_MRMOVQ) ||
              (hz.M_icode == I_CALL)   || (hz.M_icode == I_RET)    ||
              (hz.M_icode == I_PUSHQ)  || (hz.M_icode == I_POPQ);
    exc_m   = is_exc(hz.m_stat);
    exc_w   = is_exc(hz.W_stat);
  end

  // Next-state logic for the memory-wait / halt FSM; hold marks a wait-state cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_w) begin
          state_d = S_HALT;
        end else if (HAS_WAIT && mem_op) begin
          hold    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = LONG_WAIT ? S_WAIT : S_RELEASE;
        end
      end
      S_WAIT: begin
        hold = 1'b1;
        if (exc_w) begin
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = exc_w ? S_HALT : S_IDLE;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Stage controls: reset forces zero, then halt, then memory hold, then classic terms.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_stall  = 1'b0;
    e_bubble = 1'b0;
    m_stall  = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    halted   = 1'b0;
    mem_busy = 1'b0;
    if (!rst) begin
      if (state_q == S_HALT) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_stall = 1'b1;
        m_stall = 1'b1;
        w_stall = 1'b1;
        halted  = 1'b1;
      end else if (hold) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_stall  = 1'b1;
        m_stall  = 1'b1;
        w_bubble = 1'b1;
        mem_busy = 1'b1;
        w_stall  = exc_w;
      end else begin
        f_stall  = loaduse | ret;
        d_stall  = loaduse;
        d_bubble = mispred | (ret & !loaduse);
        e_bubble = mispred | loaduse;
        m_bubble = exc_m | exc_w;
        w_stall  = exc_w;
      end
    end
  end

  assign hz.F_stall  = f_stall;
  assign hz.D_stall  = d_stall;
  assign hz.D_bubble = d_bubble;
  assign hz.E_stall  = e_stall;
  assign hz.E_bubble = e_bubble;
  assign hz.M_stall  = m_stall;
  assign hz.M_bubble = m_bubble;
  assign hz.W_stall  = w_stall;
  assign hz.W_bubble = w_bubble;
  assign hz.halted   = halted;
  assign hz.mem_busy = mem_busy;

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q,   cnt_stall_d;
  logic [CNT_W-1:0] cnt_bubble_q,  cnt_bubble_d;
  logic [CNT_W-1:0] cnt_memwait_q, cnt_memwait_d;

  // Event counters wrap naturally and freeze once halted.
  always_comb begin
    cnt_stall_d   = cnt_stall_q;
    cnt_bubble_d  = cnt_bubble_q;
    cnt_memwait_d = cnt_memwait_q;
    if (state_q != S_HALT) begin
      if (f_stall)             cnt_stall_d   = cnt_stall_q + CNT_W'(1);
      if (d_bubble | e_bubble) cnt_bubble_d  = cnt_bubble_q + CNT_W'(1);
      if (mem_busy)            cnt_memwait_d = cnt_memwait_q + CNT_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_stall_q   <= '0;
      cnt_bubble_q  <= '0;
      cnt_memwait_q <= '0;
    end else begin
      cnt_stall_q   <= cnt_stall_d;
      cnt_bubble_q  <= cnt_bubble_d;
      cnt_memwait_q <= cnt_memwait_d;
    end
  end

  assign cnt_stall   = cnt_stall_q;
  assign cnt_bubble  = cnt_bubble_q;
  assign cnt_memwait = cnt_memwait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one MEM_LAT=1 and one MEM_LAT=4 instance share
// the same stimulus. Output vectors are packed as
// {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, halted, mem_busy}.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [10:0] ZERO  = 11'b000_0000_0000;
  localparam logic [10:0] LU    = 11'b110_0100_0000;
  localparam logic [10:0] HOLD  = 11'b110_1010_0101;
  localparam logic [10:0] HALTV = 11'b110_1010_1010;

  pipe_hazard_ctrl_if if1();
  pipe_hazard_ctrl_if if4();

  assign if1.D_icode = D_icode;  assign if4.D_icode = D_icode;
  assign if1.d_srcA  = d_srcA;   assign if4.d_srcA  = d_srcA;
  assign if1.d_srcB  = d_srcB;   assign if4.d_srcB  = d_srcB;
  assign if1.E_icode = E_icode;  assign if4.E_icode = E_icode;
  assign if1.E_dstM  = E_dstM;   assign if4.E_dstM  = E_dstM;
  assign if1.e_Cnd   = e_Cnd;    assign if4.e_Cnd   = e_Cnd;
  assign if1.M_icode = M_icode;  assign if4.M_icode = M_icode;
  assign if1.m_stat  = m_stat;   assign if4.m_stat  = m_stat;
  assign if1.W_stat  = W_stat;   assign if4.W_stat  = W_stat;

  pipe_hazard_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .hz(if1)
`ifdef HAZ_PERF_CNT_EN
    , .cnt_stall(), .cnt_bubble(), .cnt_memwait()
`endif
  );
  pipe_hazard_ctrl #(.MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .hz(if4)
`ifdef HAZ_PERF_CNT_EN
    , .cnt_stall(), .cnt_bubble(), .cnt_memwait()
`endif
  );

  logic [10:0] o1, o4;
  assign o1 = {if1.F_stall, if1.D_stall, if1.D_bubble, if1.E_stall, if1.E_bubble, if1.M_stall,
               if1.M_bubble, if1.W_stall, if1.W_bubble, if1.halted, if1.mem_busy};
  assign o4 = {if4.F_stall, if4.D_stall, if4.D_bubble, if4.E_stall, if4.E_bubble, if4.M_stall,
               if4.M_bubble, if4.W_stall, if4.W_bubble, if4.halted, if4.mem_busy};

`ifdef HAZ_PERF_CNT_EN
  logic rst3;
  logic [31:0] c_stall, c_bubble, c_memwait;
  pipe_hazard_ctrl_if if3();
  assign if3.D_icode = D_icode;
  assign if3.d_srcA  = d_srcA;
  assign if3.d_srcB  = d_srcB;
  assign if3.E_icode = E_icode;
  assign if3.E_dstM  = E_dstM;
  assign if3.e_Cnd   = e_Cnd;
  assign if3.M_icode = M_icode;
  assign if3.m_stat  = m_stat;
  assign if3.W_stat  = W_stat;
  pipe_hazard_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst3), .hz(if3),
    .cnt_stall(c_stall), .cnt_bubble(c_bubble), .cnt_memwait(c_memwait));
`endif

  task automatic nop();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd  = 1'b1;
    M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string tag, input logic [10:0] e1, input logic [10:0] e4);
    #1;
    n_chk++;
    assert (o1 === e1) else begin
      n_fail++;
      $error("FAIL %s lat1 observed=%b expected=%b", tag, o1, e1);
    end
    n_chk++;
    assert (o4 === e4) else begin
      n_fail++;
      $error("FAIL %s lat4 observed=%b expected=%b", tag, o4, e4);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef HAZ_PERF_CNT_EN
    rst3 = 1'b1;
`endif
    nop();
    rst = 1'b1;
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; M_icode = 4'h5;
    #2;
    check2("reset_forced_zero", ZERO, ZERO);

    @(negedge clk);
    rst = 1'b0;
    nop();
    check2("idle_nop", ZERO, ZERO); tick();

    // Classic hazards (M holds a NOP, so both instances agree)
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    check2("loaduse_srcA", LU, LU); tick();
    nop(); E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6;
    check2("loaduse_popq_srcB", LU, LU); tick();
    nop(); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
    check2("loaduse_rnone", ZERO, ZERO); tick();
    nop(); E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    check2("mispred_ret", 11'b101_0100_0000, 11'b101_0100_0000); tick();
    nop(); E_icode = 4'h7; e_Cnd = 1'b1;
    check2("jxx_taken", ZERO, ZERO); tick();
    nop(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    check2("ret_with_loaduse", LU, LU); tick();
    nop(); E_icode = 4'h9;
    check2("ret_in_E", 11'b101_0000_0000, 11'b101_0000_0000); tick();
    nop(); m_stat = 3'd3;
    check2("m_stat_exc", 11'b000_0001_0000, 11'b000_0001_0000); tick();

    // Memory wait: MRMOVQ held in M for four cycles, then PUSHQ back-to-back
    nop(); M_icode = 4'h5;
    check2("mem1_hold1", ZERO, HOLD); tick();
    check2("mem1_hold2", ZERO, HOLD); tick();
    check2("mem1_hold3", ZERO, HOLD); tick();
    check2("mem1_release", ZERO, ZERO); tick();
    M_icode = 4'hA;
    check2("mem2_hold1", ZERO, HOLD); tick();
    E_icode = 4'h7; e_Cnd = 1'b0;
    check2("mem2_hold2_mispred", 11'b001_0100_0000, HOLD); tick();
    E_icode = 4'h1; e_Cnd = 1'b1;
    check2("mem2_hold3", ZERO, HOLD); tick();
    nop();
    check2("mem2_release", ZERO, ZERO); tick();

    // Exception reaches W during the second WAIT cycle
    M_icode = 4'h5;
    check2("halt_seq_hold1", ZERO, HOLD); tick();
    check2("halt_seq_wait1", ZERO, HOLD); tick();
    W_stat = 3'd3;
    #1;
    chkv("wait2_exc_wstall", {31'd0, if4.W_stall}, 32'd1);
    chkv("lat1_exc_w_classic", {21'd0, o1}, {21'd0, 11'b000_0001_1000});
    tick();
    nop();
    check2("halted_after_exc", HALTV, HALTV); tick();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9; M_icode = 4'h5;
    check2("halt_sticky", HALTV, HALTV); tick();
    nop();
    check2("halt_sticky_nop", HALTV, HALTV); tick();

    // Reset asserted mid-WAIT
    rst = 1'b1;
    check2("rst_from_halt", ZERO, ZERO);
    @(negedge clk);
    rst = 1'b0;
    nop(); M_icode = 4'h5;
    check2("post_rst_hold1", ZERO, HOLD); tick();
    check2("post_rst_wait1", ZERO, HOLD);
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    rst = 1'b1;
    check2("rst_mid_wait", ZERO, ZERO); tick();
    @(negedge clk);
    rst = 1'b0;
    nop();
    check2("after_rst_idle", ZERO, ZERO); tick();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    check2("after_rst_loaduse", LU, LU); tick();
    nop(); M_icode = 4'h5;
    check2("fresh_hold1", ZERO, HOLD); tick();
    check2("fresh_hold2", ZERO, HOLD); tick();
    check2("fresh_hold3", ZERO, HOLD); tick();
    nop();
    check2("fresh_release", ZERO, ZERO); tick();

`ifdef HAZ_PERF_CNT_EN
    // MEM_LAT=3: two memory ops (2 hold cycles each) plus one load-use
    @(negedge clk);
    rst3 = 1'b0;
    nop(); M_icode = 4'h5; tick(); tick();
    M_icode = 4'h1; tick();
    M_icode = 4'hA; tick(); tick();
    M_icode = 4'h1; tick();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; tick();
    nop();
    #1;
    chkv("cnt_memwait", c_memwait, 32'd4);
    chkv("cnt_stall", c_stall, 32'd5);
    chkv("cnt_bubble", c_bubble, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised next-generation pipeline control unit for the Y86 PIPE processor. It generates the per-stage stall and bubble controls for F, D, E, M and W. It covers load-use, ret, branch-mispredict and exception hazards, and adds a multi-cycle data-memory wait FSM and a sticky halt state. It sits beside the stage registers and drives their stall/bubble inputs.

Parameters:
ICODE_W, 4, instruction code width
REG_W, 4, register ID width; all-ones = RNONE
STAT_W, 3, status code width (BUB=0, AOK=1, HLT=2, ADR=3, INS=4)
MEM_LAT, 1, data-memory latency in cycles (>=1); 1 = no wait states
CNT_W, 32, performance counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
D_icode  in  ICODE_W  icode in D
d_srcA  in  REG_W  decoded source A
d_srcB  in  REG_W  decoded source B
E_icode  in  ICODE_W  icode in E
E_dstM  in  REG_W  memory destination in E
e_Cnd  in  1  branch condition from E
M_icode  in  ICODE_W  icode in M
m_stat  in  STAT_W  status leaving M
W_stat  in  STAT_W  status in W
F_stall  out  1  hold F
D_stall  out  1  hold D
D_bubble  out  1  insert bubble into D
E_stall  out  1  hold E (memory wait only)
E_bubble  out  1  insert bubble into E
M_stall  out  1  hold M (memory wait only)
M_bubble  out  1  insert bubble into M
W_stall  out  1  hold W
W_bubble  out  1  insert bubble into W (memory wait only)
halted  out  1  sticky halt/exception reached W
mem_busy  out  1  memory wait hold active this cycle

Behaviour:
- Reset: state=IDLE, cnt=0, halted=0. While rst is high, all outputs are forced to 0.
- Outputs are combinational from the FSM state and current inputs. The FSM updates on the clk rising edge.
- Icodes: MRMOVQ=5, POPQ=B, RET=9, JXX=7. Memory ops are RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B.
- exc(s) = s in {HLT, ADR, INS}.
- Classic terms:
  - loaduse = E_icode in {MRMOVQ, POPQ} && E_dstM != RNONE && E_dstM in {d_srcA, d_srcB}.
  - ret = RET in any of D_icode, E_icode, M_icode.
  - mispred = E_icode==JXX && !e_Cnd.
- Classic outputs:
  - F_stall = loaduse | ret.
  - D_stall = loaduse.
  - D_bubble = mispred | (ret & !loaduse).
  - E_bubble = mispred | loaduse.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
- FSM states: IDLE, WAIT, RELEASE, HALT.
- IDLE:
  - If exc(W_stat): go to HALT.
  - Else if M_icode is a memory op and MEM_LAT>1: hold this cycle. Load cnt=MEM_LAT-2. Go to WAIT if MEM_LAT>2, else RELEASE.
- WAIT: hold. cnt decrements each cycle. When cnt==1, go to RELEASE.
- RELEASE: no hold; M advances. Go to IDLE. This prevents re-triggering on the same instruction.
- Total hold = exactly MEM_LAT-1 cycles per memory op. Back-to-back memory ops each incur the full hold.
- Hold cycle outputs:
  - F_stall, D_stall, E_stall, M_stall, W_bubble = 1; mem_busy = 1.
  - D_bubble, E_bubble, M_bubble = 0, overriding the classic terms.
  - W_stall is the classic term.
- HALT: entered from any state when exc(W_stat), including mid-WAIT, which aborts the wait.
  - Sticky until rst; halted=1.
  - F_stall=D_stall=E_stall=M_stall=W_stall=1; all bubbles 0; mem_busy=0.
- Priority: rst > HALT > memory hold > classic terms.
- With MEM_LAT=1, the FSM never leaves IDLE except to HALT. Outputs then equal the classic PIPE control.

Optional Feature:
- Macro HAZ_PERF_CNT_EN defined adds outputs cnt_stall, cnt_bubble, cnt_memwait, each CNT_W bits.
  - cnt_stall increments on cycles with F_stall=1.
  - cnt_bubble increments on cycles with D_bubble|E_bubble.
  - cnt_memwait increments on mem_busy cycles.
  - All are cleared by rst, wrap modulo 2^CNT_W, and freeze in HALT.
- Macro undefined: the ports are absent and no counter logic is built.

Test Plan:
- MEM_LAT=1, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
- MEM_LAT=1, E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1.
- MEM_LAT=4, M_icode=5 for 4 cycles -> mem_busy=1 and E_stall=M_stall=W_bubble=1 exactly 3 cycles, then one RELEASE cycle with mem_busy=0; M_icode=A next -> 3 more hold cycles.
- MEM_LAT=4, W_stat=3 asserted during the 2nd WAIT cycle -> next cycle halted=1, W_stall=1, mem_busy=0; stays so after W_stat returns to 1, until rst.
- rst asserted mid-WAIT -> all outputs 0 immediately; after release, state is IDLE with classic behaviour.
- HAZ_PERF_CNT_EN, MEM_LAT=3, two memory ops plus one load-use -> cnt_memwait=4, cnt_stall=5, cnt_bubble=1.
